// File: rtl/hex_entry_reader_pkg.sv
// Shared types and constants for the hex entry reader.
package hex_entry_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DIG_W            = 3;
    localparam int DIGITS_PER_ENTRY = 4;

endpackage

// File: rtl/hex_entry_reader_if.sv
// Switch/button inputs and entry-register outputs of the hex entry reader.
interface hex_entry_reader_if;
    import hex_entry_reader_pkg::*;

    logic [3:0]       sw;
    logic             btn_enter;
    logic             btn_clear;
    logic [15:0]      packedHex;
    logic [DIG_W-1:0] digits;
    logic             valid;
    logic             timeout;

    modport master (output sw, btn_enter, btn_clear,
                    input  packedHex, digits, valid, timeout);
    modport slave  (input  sw, btn_enter, btn_clear,
                    output packedHex, digits, valid, timeout);
endinterface

// File: rtl/hex_entry_reader_debounce_pulse.sv
// Two-flop synchronizer plus debouncer for one raw pushbutton; emits the
// debounced level and a registered one-cycle pulse on its rising edge.
module debounce_pulse #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic arst,
    input  logic din,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk) begin
        if (arst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync    <= {sync[0], din};
            level_d <= level;
            rise    <= level & ~level_d;
            // cnt counts consecutive samples that disagree with the current level
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hex_entry_reader.sv
// Four-digit hex entry from slide switches and enter/clear buttons.
// Optional idle-abort timeout in COLLECT is compiled in by HEX_ENTRY_TIMEOUT_EN.
module hex_entry_reader
    import hex_entry_reader_pkg::*;
#(
    parameter int NUM_SEC        = 1,
    parameter int CRYSTAL        = 100,
    parameter int C              = 35,
    parameter int TIMEOUT_CYCLES = CRYSTAL * 1_000_000 * NUM_SEC,
    parameter int DB_CYCLES      = 1_000_000
) (
    input  logic                 clk,
    input  logic                 arst,
    hex_entry_reader_if.slave    bus
);
    logic enter, clear;
    logic ent_lvl_unused, clr_lvl_unused;

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
        .clk(clk), .arst(arst), .din(bus.btn_enter),
        .level(ent_lvl_unused), .rise(enter)
    );

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk(clk), .arst(arst), .din(bus.btn_clear),
        .level(clr_lvl_unused), .rise(clear)
    );

    state_t           state_q, state_n;
    logic [15:0]      hex_q, hex_n;
    logic [DIG_W-1:0] digits_q, digits_n;
    logic             valid_q, valid_n;
    logic             timeout_q, timeout_n;
    logic [DIG_W-1:0] digits_inc;
    logic             entry_full;
    logic             idle_expired;

    assign digits_inc = digits_q + 1'b1;
    assign entry_full = (digits_inc == DIG_W'(DIGITS_PER_ENTRY));

`ifdef HEX_ENTRY_TIMEOUT_EN
    localparam logic [C-1:0] IDLE_LAST = C'(TIMEOUT_CYCLES - 1);

    logic [C-1:0] idle_q, idle_n;

    assign idle_expired = (state_q == COLLECT) && (idle_q == IDLE_LAST);

    always_comb begin
        idle_n = '0;
        if (!clear && !enter && state_q == COLLECT && !idle_expired)
            idle_n = idle_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (arst) idle_q <= '0;
        else      idle_q <= idle_n;
    end
`else
    logic cfg_unused;
    assign cfg_unused   = ^{C[0], TIMEOUT_CYCLES[0]};
    assign idle_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= IDLE;
            hex_q     <= '0;
            digits_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            hex_q     <= hex_n;
            digits_q  <= digits_n;
            valid_q   <= valid_n;
            timeout_q <= timeout_n;
        end
    end

    // Clear beats enter, and an accepted enter suppresses a coincident timeout.
    always_comb begin
        state_n = state_q;
        if (clear) begin
            state_n = IDLE;
        end else if (enter) begin
            if (state_q == COLLECT) state_n = entry_full ? DONE : COLLECT;
            else                    state_n = COLLECT;
        end else if (idle_expired) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        hex_n     = hex_q;
        digits_n  = digits_q;
        valid_n   = 1'b0;
        timeout_n = 1'b0;
        if (clear) begin
            hex_n    = '0;
            digits_n = '0;
        end else if (enter) begin
            if (state_q == COLLECT) begin
                hex_n    = {hex_q[11:0], bus.sw};
                digits_n = digits_inc;
                valid_n  = entry_full;
            end else begin
                hex_n    = {12'h000, bus.sw};
                digits_n = DIG_W'(1);
            end
        end else if (idle_expired) begin
            hex_n     = '0;
            digits_n  = '0;
            timeout_n = 1'b1;
        end
    end

    assign bus.packedHex = hex_q;
    assign bus.digits    = digits_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_hex_entry_reader.sv
// Directed bench for hex_entry_reader; valid/timeout pulses are checked
// against a scoreboard of expected events.
module tb_hex_entry_reader;
    import hex_entry_reader_pkg::*;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    hex_entry_reader_if bus();

    hex_entry_reader #(.DB_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .arst(arst), .bus(bus)
    );

    typedef struct {
        logic        is_to;
        logic [15:0] hex;
    } ev_t;

    ev_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  n_valid  = 0;
    int  n_to     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (arst === 1'b0 && (bus.valid === 1'b1 || bus.timeout === 1'b1)) begin
            if (bus.valid === 1'b1)   n_valid++;
            if (bus.timeout === 1'b1) n_to++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", {30'b0, bus.valid, bus.timeout}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", {31'b0, bus.timeout}, {31'b0, e.is_to});
                chk("sb_hex", {16'b0, bus.packedHex}, {16'b0, e.hex});
            end
        end
    end

    task automatic press(input logic [3:0] v, input logic ent, input logic clr);
        @(negedge clk);
        bus.sw        = v;
        bus.btn_enter = ent;
        bus.btn_clear = clr;
        repeat (10) @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] hex, input int dig);
        chk({tag, "_hex"}, {16'b0, bus.packedHex}, {16'b0, hex});
        chk({tag, "_digits"}, 32'(bus.digits), 32'(dig));
    endtask

    initial begin
        int nv, nt;
        bus.sw        = 4'h0;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        arst          = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("reset", 16'h0000, 0);
        chk("reset_valid", {31'b0, bus.valid}, 32'h0);
        chk("reset_timeout", {31'b0, bus.timeout}, 32'h0);
        arst = 1'b0;

        // ABCD entry
        press(4'hA, 1, 0); chk_out("d1", 16'h000A, 1);
        press(4'hB, 1, 0); chk_out("d2", 16'h00AB, 2);
        press(4'hC, 1, 0); chk_out("d3", 16'h0ABC, 3);
        sb.push_back('{is_to: 1'b0, hex: 16'hABCD});
        nv = n_valid;
        press(4'hD, 1, 0);
        chk_out("abcd", 16'hABCD, 4);
        chk("abcd_valid_count", 32'(n_valid - nv), 32'd1);
        chk("abcd_state", 32'(dut.state_q), 32'(DONE));

        // restart from DONE
        press(4'h0, 0, 1); chk_out("clear1", 16'h0000, 0);
        press(4'h1, 1, 0);
        press(4'h2, 1, 0);
        press(4'h3, 1, 0);
        sb.push_back('{is_to: 1'b0, hex: 16'h1234});
        press(4'h4, 1, 0); chk_out("e1234", 16'h1234, 4);
        press(4'h7, 1, 0); chk_out("done_restart", 16'h0007, 1);
        press(4'h0, 0, 1); chk_out("clear2", 16'h0000, 0);

        // bounce shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus.sw = 4'hF; bus.btn_enter = 1'b1;
            @(negedge clk);
            @(negedge clk); bus.btn_enter = 1'b0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk_out("bounce", 16'h0000, 0);

        // enter and clear together: clear wins
        press(4'h2, 1, 0);
        press(4'h5, 1, 0); chk_out("pre_both", 16'h0025, 2);
        press(4'h9, 1, 1);
        chk_out("both", 16'h0000, 0);
        chk("both_state", 32'(dut.state_q), 32'(IDLE));

        // reset mid-entry
        press(4'h6, 1, 0);
        press(4'h8, 1, 0);
        @(negedge clk); arst = 1'b1;
        @(negedge clk);
        chk_out("mid_reset", 16'h0000, 0);
        chk("mid_reset_valid", {31'b0, bus.valid}, 32'h0);
        chk("mid_reset_timeout", {31'b0, bus.timeout}, 32'h0);
        arst = 1'b0;
        press(4'h9, 1, 0); chk_out("after_reset", 16'h0009, 1);
        press(4'h0, 0, 1); chk_out("clear3", 16'h0000, 0);

        // idle in COLLECT
        press(4'h3, 1, 0);
        press(4'h5, 1, 0);
        nt = n_to;
`ifdef HEX_ENTRY_TIMEOUT_EN
        sb.push_back('{is_to: 1'b1, hex: 16'h0000});
        repeat (60) @(negedge clk);
        chk("timeout_count", 32'(n_to - nt), 32'd1);
        chk_out("timeout", 16'h0000, 0);
        chk("timeout_state", 32'(dut.state_q), 32'(IDLE));
`else
        repeat (200) @(negedge clk);
        chk("no_timeout_count", 32'(n_to - nt), 32'd0);
        chk_out("no_timeout", 16'h0035, 2);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hex_entry_reader.md
HEX_ENTRY_READER -- requirements
Module: hex_entry_reader

Interface
REQ-001 SHALL have parameter NUM_SEC, default 1: entry timeout in seconds.
REQ-002 SHALL have parameter CRYSTAL, default 100: clock frequency in MHz.
REQ-003 SHALL have parameter C, default 35: width of the timeout counter.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default CRYSTAL*1_000_000*NUM_SEC: idle cycles before abort; overridable for simulation.
REQ-005 SHALL have parameter DB_CYCLES, default 1_000_000: debounce stability window in cycles, minimum 1.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port arst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port sw, input, 4: hex nibble from the slide switches.
REQ-009 SHALL have port btn_enter, input, 1: raw, asynchronous enter pushbutton.
REQ-010 SHALL have port btn_clear, input, 1: raw, asynchronous clear pushbutton.
REQ-011 SHALL have port packedHex, output, 16: the entry register; wires directly to the hex display block.
REQ-012 SHALL have port digits, output, 3: digits entered so far, 0..4.
REQ-013 SHALL have port valid, output, 1: one-cycle pulse when the 4th digit is accepted.
REQ-014 SHALL have port timeout, output, 1: one-cycle pulse on a timeout abort.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DB_CYCLES consecutive equal synchronized samples.
REQ-016 A debounced 0->1 transition SHALL produce a one-cycle press pulse; the pulse is registered at edge 2+DB_CYCLES+1 after the raw input is first sampled high, and the input is held high throughout.
REQ-017 The state machine SHALL have three states: IDLE, COLLECT and DONE.
REQ-018 On an enter pulse in IDLE or DONE: packedHex <= {12'h000, sw}, digits <= 1, and the state moves to COLLECT.
REQ-019 On an enter pulse in COLLECT: packedHex <= {packedHex[11:0], sw} and digits increments; when digits becomes 4, valid pulses in the same cycle and the state moves to DONE.
REQ-020 sw SHALL be sampled only in the cycle of the enter pulse.
REQ-021 In DONE, packedHex and digits SHALL hold indefinitely; the timeout is not active in DONE.
REQ-022 A clear pulse in any state SHALL set packedHex to 0 and digits to 0, and move the state to IDLE.
REQ-023 If clear and enter pulse in the same cycle, clear SHALL win and the enter is discarded.
REQ-024 In COLLECT, an idle counter SHALL increment every cycle and be zeroed by each accepted enter.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES-1, the block SHALL go to IDLE with packedHex=0 and digits=0, and pulse timeout.
REQ-026 An enter in the same cycle as the timeout SHALL be accepted, and the timeout is suppressed.
REQ-027 Holding a button down SHALL generate exactly one pulse; bounce shorter than DB_CYCLES SHALL generate none.

Reset
REQ-028 On arst high at a clk edge, the block SHALL set packedHex=0, digits=0, valid=0, timeout=0, state=IDLE, and zero the idle counter.
REQ-029 On the same reset, the synchronizers and debouncers SHALL be set to 0 (released).
REQ-030 Reset SHALL take priority over all other events; reset mid-entry discards the partial value.
REQ-031 A button held through reset release SHALL produce a press only after the full debounce window has elapsed.

Configuration
REQ-032 Macro HEX_ENTRY_TIMEOUT_EN: when defined, the idle counter and timeout behaviour (REQ-024..REQ-026) SHALL be compiled in.
REQ-033 When HEX_ENTRY_TIMEOUT_EN is undefined, there SHALL be no idle counter, timeout SHALL be tied to 0, and COLLECT SHALL wait indefinitely.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/COLLECT/DONE), the digit-count width constant (3) and the constant 4 for digits per entry.
REQ-035 The debouncer SHALL be a sub-module, debounce_pulse (parameter DB_CYCLES), instantiated once per button; it outputs the level and a rise pulse.

Verification (DB_CYCLES=4, TIMEOUT_CYCLES=50, macro defined)
REQ-036 Press enter with sw=A, B, C, D (each held 10 cycles, released 10) -> packedHex=16'hABCD; valid high exactly one cycle, on the 4th acceptance; digits=4.
REQ-037 Toggle btn_enter high/low every 2 cycles for 20 cycles -> no press accepted; digits stays 0.
REQ-038 Enter 3 and 5, then stay idle 50 cycles -> timeout pulses once; packedHex=0; digits=0.
REQ-039 Align enter and clear pulses in the same cycle after 2 digits -> packedHex=0; digits=0; IDLE.
REQ-040 In DONE with 16'h1234, press enter with sw=7 -> packedHex=16'h0007; digits=1.
REQ-041 Assert arst after 2 digits -> next cycle all outputs are 0; the following entry starts from digit 1.
REQ-042 Rebuild without the macro and stay idle 200 cycles in COLLECT -> no timeout; value retained.
